// File: rtl/axi_burst_writer.sv
// axi_burst_writer: writes the upstream word stream to the frame buffer as fixed-length AXI4 INCR bursts.
// One burst is outstanding at a time; addresses advance linearly and wrap at the frame end or restart on frame_i.
module axi_burst_writer #(
  parameter int W = 64,
  parameter int AW = 32,
  parameter int BURST = 16,
  parameter logic [AW-1:0] BASE = 32'h1000_0000,
  parameter logic [AW-1:0] FRAME_BYTES = 32'h0060_0000
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            srst_i,
  input  logic            frame_i,
  input  logic            in_val_i,
  input  logic [W-1:0]    in_data_i,
  output logic            in_rdy_o,
  output logic [AW-1:0]   awaddr_o,
  output logic [7:0]      awlen_o,
  output logic [2:0]      awsize_o,
  output logic [1:0]      awburst_o,
  output logic            awvalid_o,
  input  logic            awready_i,
  output logic [W-1:0]    wdata_o,
  output logic [W/8-1:0]  wstrb_o,
  output logic            wlast_o,
  output logic            wvalid_o,
  input  logic            wready_i,
  input  logic [1:0]      bresp_i,
  input  logic            bvalid_i,
  output logic            bready_o,
  output logic            err_o,
  output logic            busy_o
);
  localparam int BW = $clog2(BURST + 1);
  localparam logic [AW-1:0] STEP = AW'(BURST * W / 8);
  localparam logic [AW-1:0] LIMIT = BASE + FRAME_BYTES;
  localparam logic [BW-1:0] LAST = BW'(BURST - 1);
  typedef enum logic [1:0] {IDLE, ADDR, DATA, RESP} state_t;
  state_t state, state_nxt;
  logic [AW-1:0] addr, start, inc;
  logic [BW-1:0] beat;
  logic pend, issue, beat_hs;
  assign issue = state == IDLE && in_val_i;
  assign beat_hs = state == DATA && in_val_i && wready_i;
  // a pending or same-cycle frame pulse restarts the burst at BASE
  assign start = (pend || frame_i) ? BASE : addr;
  assign inc = start + STEP;
  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) state <= IDLE;
    else state <= srst_i ? IDLE : state_nxt;
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: state_nxt = in_val_i ? ADDR : IDLE;
      ADDR: state_nxt = awready_i ? DATA : ADDR;
      DATA: state_nxt = (beat_hs && beat == LAST) ? RESP : DATA;
      RESP: state_nxt = bvalid_i ? IDLE : RESP;
      default: state_nxt = IDLE;
    endcase
  end
  always_comb begin
    awvalid_o = state == ADDR;
    wvalid_o = state == DATA && in_val_i;
    in_rdy_o = state == DATA && wready_i;
    wlast_o = state == DATA && beat == LAST;
    bready_o = state == RESP;
    busy_o = state != IDLE;
    wdata_o = in_data_i;
    wstrb_o = '1;
    awlen_o = 8'(BURST - 1);
    awsize_o = 3'($clog2(W / 8));
    awburst_o = 2'b01;
  end
  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) begin
      addr <= BASE;
      awaddr_o <= BASE;
      beat <= '0;
      pend <= 1'b0;
      err_o <= 1'b0;
    end else if (srst_i) begin
      addr <= BASE;
      awaddr_o <= BASE;
      beat <= '0;
      pend <= 1'b0;
      err_o <= 1'b0;
    end else begin
      if (issue) begin
        awaddr_o <= start;
        addr <= (inc == LIMIT) ? BASE : inc;
      end
      pend <= issue ? 1'b0 : pend | frame_i;
      if (beat_hs) beat <= (beat == LAST) ? '0 : beat + BW'(1);
      if (state == RESP && bvalid_i && bresp_i != 2'b00) err_o <= 1'b1;
    end
endmodule
